// File: rtl/pixel_frame_parser_if.sv
// rtl/pixel_frame_parser_if.sv - pixel word stream into the frame parser
interface pixel_frame_parser_if;
  logic        pixel_valid;
  logic [63:0] pixel_value;

  modport master (output pixel_valid, output pixel_value);
  modport slave  (input  pixel_valid, input  pixel_value);
endinterface

// File: rtl/pixel_frame_parser.sv
// rtl/pixel_frame_parser.sv - SOF/header/payload/EOF framing of 6-byte pixel words
module pixel_frame_parser #(
  parameter int unsigned MAX_LEN    = 32'h002b,
  parameter int unsigned HDR_WORDS  = 2,
  parameter logic [7:0]  EXP_PHL_ID = 8'h00
) (
  input  logic                   rx_pixel_clk,
  input  logic                   rst_n,
  pixel_frame_parser_if.slave    px,
  output logic [MAX_LEN*8-1:0]   data,
  output logic [31:0]            data_len,
  output logic [7:0]             dtype,
  output logic [7:0]             phl_id,
  output logic                   frame_valid,
  output logic                   frame_error,
  output logic [1:0]             err_code,
  output logic                   busy
);

  localparam int unsigned DW         = MAX_LEN * 8;
  localparam int unsigned IDX_W      = $clog2(DW);
  localparam logic [31:0] HDR_LAST   = 32'(HDR_WORDS - 1);
  localparam logic [31:0] MAX_LEN_W  = 32'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_EOF_AA, S_EOF_DD} state_t;

  state_t          state_q, state_d;
  logic [31:0]     hdr_cnt_q, hdr_cnt_d;
  logic [47:0]     first_hdr_q, first_hdr_d;
  logic [31:0]     k_q, k_d;
  logic [31:0]     dlen_q, dlen_d;
  logic [7:0]      hdr_dtype_q, hdr_dtype_d;
  logic [7:0]      hdr_phl_q, hdr_phl_d;
  logic [DW-1:0]   stage_q, stage_d;
  logic [DW-1:0]   data_q, data_d;
  logic [31:0]     data_len_q, data_len_d;
  logic [7:0]      dtype_q, dtype_d;
  logic [7:0]      phl_id_q, phl_id_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_error_q, frame_error_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            busy_q, busy_d;

  logic [47:0]     w;
  logic            valid;
  logic [31:0]     hdr_dlen;
  logic [31:0]     r;
  logic [2:0]      r_p1;
  logic [7:0]      lane_r;
  logic [7:0]      lane_r1;
  logic            unused_hi;

  assign w         = px.pixel_value[47:0];
  assign valid     = px.pixel_valid;
  assign unused_hi = ^px.pixel_value[63:48];
  assign hdr_dlen  = {w[15:8], w[23:16], w[31:24], w[39:32]};
  assign r         = dlen_q - k_q;
  assign r_p1      = r[2:0] + 3'd1;
  assign lane_r    = w[{r[2:0], 3'b000} +: 8];
  assign lane_r1   = w[{r_p1, 3'b000} +: 8];

  logic        abort;
  logic [1:0]  abort_code;
  logic        done;
  logic [31:0] byte_pos;

  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    first_hdr_d   = first_hdr_q;
    k_d           = k_q;
    dlen_d        = dlen_q;
    hdr_dtype_d   = hdr_dtype_q;
    hdr_phl_d     = hdr_phl_q;
    stage_d       = stage_q;
    data_d        = data_q;
    data_len_d    = data_len_q;
    dtype_d       = dtype_q;
    phl_id_d      = phl_id_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    err_code_d    = err_code_q;
    busy_d        = busy_q;
    abort         = 1'b0;
    abort_code    = 2'd0;
    done          = 1'b0;
    byte_pos      = 32'd0;

    unique case (state_q)
      S_IDLE: begin
        if (valid && w[15:0] == 16'hFFEA) begin
          state_d   = S_HDR;
          hdr_cnt_d = 32'd0;
          busy_d    = 1'b1;
          // Bytes past DLEN read back as zero rather than leftovers of older frames.
          stage_d   = '0;
        end
      end
      S_HDR: begin
        if (!valid) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else if ((hdr_cnt_q != 32'd0 && w != first_hdr_q) || w[47:40] != EXP_PHL_ID) begin
          abort      = 1'b1;
          abort_code = 2'd1;
        end else begin
          if (hdr_cnt_q == 32'd0) first_hdr_d = w;
          if (hdr_cnt_q == HDR_LAST) begin
            if (hdr_dlen == 32'd0 || hdr_dlen > MAX_LEN_W) begin
              abort      = 1'b1;
              abort_code = 2'd2;
            end else begin
              state_d     = S_PAYLOAD;
              k_d         = 32'd0;
              dlen_d      = hdr_dlen;
              hdr_dtype_d = w[7:0];
              hdr_phl_d   = w[47:40];
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 32'd1;
          end
        end
      end
      S_PAYLOAD: begin
        if (!valid) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else begin
          for (int i = 0; i < 6; i++) begin
            byte_pos = k_q + 32'(i);
            if (32'(i) < r && byte_pos < MAX_LEN_W)
              stage_d[IDX_W'(byte_pos * 32'd8) +: 8] = w[6'(i * 8) +: 8];
          end
          if (r >= 32'd6) begin
            k_d = k_q + 32'd6;
            if (r == 32'd6) state_d = S_EOF_AA;
          end else if (lane_r != 8'hAA) begin
            abort      = 1'b1;
            abort_code = 2'd3;
          end else if (r == 32'd5) begin
            state_d = S_EOF_DD;
          end else if (lane_r1 != 8'hDD) begin
            abort      = 1'b1;
            abort_code = 2'd3;
          end else begin
            done = 1'b1;
          end
        end
      end
      S_EOF_AA: begin
        if (!valid || w[15:0] != 16'hDDAA) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else begin
          done = 1'b1;
        end
      end
      S_EOF_DD: begin
        if (!valid || w[7:0] != 8'hDD) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else begin
          done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d       = S_IDLE;
      busy_d        = 1'b0;
      frame_error_d = 1'b1;
      err_code_d    = abort_code;
    end

    // Published fields change only here, so an aborted frame leaves them intact.
    if (done) begin
      state_d       = S_IDLE;
      busy_d        = 1'b0;
      frame_valid_d = 1'b1;
      err_code_d    = 2'd0;
      data_d        = stage_d;
      data_len_d    = dlen_q;
      dtype_d       = hdr_dtype_q;
      phl_id_d      = hdr_phl_q;
    end
  end

  always_ff @(posedge rx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hdr_cnt_q     <= '0;
      first_hdr_q   <= '0;
      k_q           <= '0;
      dlen_q        <= '0;
      hdr_dtype_q   <= '0;
      hdr_phl_q     <= '0;
      stage_q       <= '0;
      data_q        <= '0;
      data_len_q    <= '0;
      dtype_q       <= '0;
      phl_id_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      err_code_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      first_hdr_q   <= first_hdr_d;
      k_q           <= k_d;
      dlen_q        <= dlen_d;
      hdr_dtype_q   <= hdr_dtype_d;
      hdr_phl_q     <= hdr_phl_d;
      stage_q       <= stage_d;
      data_q        <= data_d;
      data_len_q    <= data_len_d;
      dtype_q       <= dtype_d;
      phl_id_q      <= phl_id_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
    end
  end

  assign data        = data_q;
  assign data_len    = data_len_q;
  assign dtype       = dtype_q;
  assign phl_id      = phl_id_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign err_code    = err_code_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pixel_frame_parser.sv
// tb/tb_pixel_frame_parser.sv - frame-level model and directed frames for pixel_frame_parser
module tb_pixel_frame_parser;
  localparam int         MAX_LEN   = 43;
  localparam int         HDR_WORDS = 2;
  localparam logic [7:0] EXP_PHL   = 8'h00;
  localparam int         DW        = MAX_LEN * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pixel_frame_parser_if px();
  logic [DW-1:0] data;
  logic [31:0]   data_len;
  logic [7:0]    dtype, phl_id;
  logic          frame_valid, frame_error, busy;
  logic [1:0]    err_code;

  pixel_frame_parser #(.MAX_LEN(MAX_LEN), .HDR_WORDS(HDR_WORDS), .EXP_PHL_ID(EXP_PHL)) dut (
    .rx_pixel_clk (clk),
    .rst_n        (rst_n),
    .px           (px),
    .data         (data),
    .data_len     (data_len),
    .dtype        (dtype),
    .phl_id       (phl_id),
    .frame_valid  (frame_valid),
    .frame_error  (frame_error),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Expected outputs after the most recent edge.
  logic [7:0]  exp_mem [MAX_LEN];
  int          exp_len = 0;
  logic [7:0]  exp_dt = 8'h00, exp_phl = 8'h00;
  logic        exp_fv = 1'b0, exp_fe = 1'b0, exp_busy = 1'b0;
  logic [1:0]  exp_err = 2'd0;

  // Frame currently being sent.
  logic [7:0]  pay [64];
  int          cur_dlen;
  logic [7:0]  cur_dt, cur_phl;

  // Hand-computed literal pins.
  logic        lit_on = 1'b0, lit_zero = 1'b0, lit_busy = 1'b0;
  int          lit_len = 0;
  logic [7:0]  lit_dt = 8'h00, lit_b0 = 8'h00, lit_blast = 8'h00;
  logic [1:0]  lit_err = 2'd0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin : compare
    int bad_b;
    if (rst_n) begin
      chk("frame_valid", 64'(frame_valid), 64'(exp_fv));
      chk("frame_error", 64'(frame_error), 64'(exp_fe));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("err_code", 64'(err_code), 64'(exp_err));
      chk("data_len", 64'(data_len), 64'(exp_len));
      chk("dtype", 64'(dtype), 64'(exp_dt));
      chk("phl_id", 64'(phl_id), 64'(exp_phl));
      bad_b = 0;
      for (int k = 0; k < MAX_LEN; k++)
        if (k < exp_len && data[8*k +: 8] !== exp_mem[k]) bad_b++;
      chk("data_bytes_wrong", 64'(bad_b), 64'd0);
    end
    if (lit_on) begin
      chk("pin_data_len", 64'(data_len), 64'(lit_len));
      chk("pin_dtype", 64'(dtype), 64'(lit_dt));
      chk("pin_err_code", 64'(err_code), 64'(lit_err));
      chk("pin_busy", 64'(busy), 64'(lit_busy));
      if (lit_zero) begin
        chk("pin_data_zero", 64'(|data), 64'd0);
        chk("pin_phl_id", 64'(phl_id), 64'd0);
        chk("pin_pulses", 64'({frame_valid, frame_error}), 64'd0);
      end else begin
        chk("pin_byte0", 64'(data[7:0]), 64'(lit_b0));
        chk("pin_byte_last", 64'(data[8*(lit_len-1) +: 8]), 64'(lit_blast));
      end
    end
  end

  task automatic pin(input int len, input logic [7:0] dt, input logic [7:0] b0, input logic [7:0] blast,
                     input logic [1:0] err, input logic bsy, input logic zero);
    lit_len = len; lit_dt = dt; lit_b0 = b0; lit_blast = blast;
    lit_err = err; lit_busy = bsy; lit_zero = zero;
    lit_on = 1'b1;
    @(negedge clk);
    #1 lit_on = 1'b0;
  endtask

  // term: -1 frame continues, 0 frame completes, 1..3 abort with that code.
  task automatic step(input logic v, input logic [63:0] w, input logic busy_after, input int term);
    px.pixel_valid = v;
    px.pixel_value = w;
    @(posedge clk);
    #1;
    exp_fv   = (term == 0);
    exp_fe   = (term > 0);
    exp_busy = busy_after;
    if (term == 0) begin
      exp_err = 2'd0;
      exp_len = cur_dlen;
      exp_dt  = cur_dt;
      exp_phl = cur_phl;
      for (int k = 0; k < MAX_LEN; k++) exp_mem[k] = pay[k];
    end else if (term > 0) begin
      exp_err = 2'(term);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b0, -1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    px.pixel_valid = 1'b0;
    exp_len = 0; exp_dt = 8'h00; exp_phl = 8'h00; exp_err = 2'd0;
    exp_fv = 1'b0; exp_fe = 1'b0; exp_busy = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) exp_mem[k] = 8'h00;
    #2;
    pin(0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // fault: 0 none, 1 header words differ, 2 AB instead of AA, 3 valid drop, 4 reset, 5 SOF bytes in payload
  task automatic run_frame(input int dlen, input logic [7:0] dt, input logic [7:0] phl, input int fault, input logic rnd);
    logic [31:0] dl;
    logic [47:0] hdr, w48;
    logic [7:0]  strm [$];
    int          nw, term, idx;
    dl = dlen;
    cur_dlen = dlen; cur_dt = dt; cur_phl = phl;
    for (int k = 0; k < 64; k++) pay[k] = rnd ? 8'($urandom_range(0, 255)) : 8'(k + 1);
    if (k_fault5(fault)) begin pay[0] = 8'hEA; pay[1] = 8'hFF; end
    if (dlen < 64) for (int k = dlen; k < 64; k++) pay[k] = 8'h00;

    step(1'b1, {16'($urandom), 32'($urandom), 16'hFFEA}, 1'b1, -1);

    hdr = {phl, dl[7:0], dl[15:8], dl[23:16], dl[31:24], dt};
    for (int i = 0; i < HDR_WORDS; i++) begin
      w48 = (fault == 1 && i == 1) ? (hdr ^ 48'h1) : hdr;
      if (w48 != hdr || phl != EXP_PHL) term = 1;
      else if (i == HDR_WORDS - 1 && (dl == 0 || dl > MAX_LEN)) term = 2;
      else term = -1;
      step(1'b1, {16'hA5A5, w48}, term < 0, term);
      if (term > 0) return;
    end

    for (int k = 0; k < dlen; k++) strm.push_back(pay[k]);
    strm.push_back(fault == 2 ? 8'hAB : 8'hAA);
    strm.push_back(8'hDD);
    nw = (dlen + 2 + 5) / 6;
    for (int j = 0; j < nw; j++) begin
      for (int l = 0; l < 6; l++) begin
        idx = 6 * j + l;
        w48[8*l +: 8] = (idx < strm.size()) ? strm[idx] : 8'($urandom_range(0, 255));
      end
      if (fault == 3 && j == 2) begin
        step(1'b0, {16'h0, w48}, 1'b0, 3);
        return;
      end
      if (fault == 4 && j == 2) begin
        do_reset();
        return;
      end
      if (fault == 2 && j == dlen / 6) term = 3;
      else if (j == nw - 1) term = 0;
      else term = -1;
      step(1'b1, {16'($urandom), w48}, term < 0, term);
      if (term >= 0) return;
    end
  endtask

  function automatic logic k_fault5(input int fault);
    return fault == 5;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    px.pixel_valid = 1'b0;
    px.pixel_value = 64'h0;
    for (int k = 0; k < MAX_LEN; k++) exp_mem[k] = 8'h00;
    #12;
    pin(0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pin(0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1);

    step(1'b1, 64'h0, 1'b0, -1);
    step(1'b1, 64'h0, 1'b0, -1);
    step(1'b1, 64'h0000_1234_5678_FFEB, 1'b0, -1);
    step(1'b0, 64'hFFFF_FFFF_FFFF_FFEA, 1'b0, -1);

    run_frame(43, 8'h01, 8'h00, 0, 1'b0);
    pin(43, 8'h01, 8'h01, 8'h2B, 2'd0, 1'b0, 1'b0);
    idle(2);
    run_frame(41, 8'h22, 8'h00, 0, 1'b0);
    pin(41, 8'h22, 8'h01, 8'h29, 2'd0, 1'b0, 1'b0);
    idle(1);
    run_frame(42, 8'h23, 8'h00, 0, 1'b0);
    pin(42, 8'h23, 8'h01, 8'h2A, 2'd0, 1'b0, 1'b0);
    idle(1);
    run_frame(44, 8'h05, 8'h00, 0, 1'b1);
    pin(42, 8'h23, 8'h01, 8'h2A, 2'd2, 1'b0, 1'b0);
    idle(1);
    run_frame(0, 8'h05, 8'h00, 0, 1'b1);
    idle(1);
    run_frame(20, 8'h07, 8'h00, 1, 1'b1);
    pin(42, 8'h23, 8'h01, 8'h2A, 2'd1, 1'b0, 1'b0);
    idle(1);
    run_frame(20, 8'h07, 8'h05, 0, 1'b1);
    idle(1);
    run_frame(20, 8'h07, 8'h00, 2, 1'b1);
    pin(42, 8'h23, 8'h01, 8'h2A, 2'd3, 1'b0, 1'b0);
    idle(1);
    run_frame(30, 8'h08, 8'h00, 3, 1'b1);
    idle(2);
    run_frame(43, 8'h09, 8'h00, 4, 1'b1);
    idle(2);
    run_frame(6, 8'h0A, 8'h00, 0, 1'b0);
    pin(6, 8'h0A, 8'h01, 8'h06, 2'd0, 1'b0, 1'b0);
    run_frame(1, 8'h0B, 8'h00, 0, 1'b1);
    run_frame(12, 8'h0C, 8'h00, 5, 1'b1);
    run_frame(5, 8'h0D, 8'h00, 0, 1'b0);
    pin(5, 8'h0D, 8'h01, 8'h05, 2'd0, 1'b0, 1'b0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
